// File: rtl/aes_mix_columns_iter_if.sv
// ============================================================================
// aes_mix_columns_iter_if : input/output valid-ready bundle for MixColumns
// Rev 1.0 ; MIX_COLUMNS_INV_EN adds inv_mode
// ============================================================================
`default_nettype none

interface aes_mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         last_round;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv_mode;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    modport master (
`ifdef MIX_COLUMNS_INV_EN
        output inv_mode,
`endif
        output in_valid, data_in, last_round, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
`ifdef MIX_COLUMNS_INV_EN
        input  inv_mode,
`endif
        input  in_valid, data_in, last_round, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

`default_nettype wire

// File: rtl/aes_mix_columns_iter.sv
// ============================================================================
// aes_mix_columns_iter : iterative AES MixColumns, COLS_PER_CYCLE columns/clk
// Rev 1.0 ; MIX_COLUMNS_INV_EN adds InvMixColumns selected by inv_mode
// ============================================================================
`default_nettype none

module aes_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_mix_columns_iter_if.slave  bus
);

    localparam int ITERS = 4 / COLS_PER_CYCLE;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [2:0]   col_q, col_d;
    logic         last_q, last_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] data_out_q, data_out_d;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv_q, inv_d;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // 9/11/13/14 multiples from one x2/x4/x8 chain per byte
    function automatic logic [31:0] mix_inv(input logic [31:0] a);
        logic [7:0] x1 [4];
        logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            x1[i]  = a[31-8*i -: 8];
            x2     = xtime(x1[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ x1[i];
            m11[i] = x8 ^ x2 ^ x1[i];
            m13[i] = x8 ^ x4 ^ x1[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction
`endif

    function automatic logic [127:0] calc_step(input logic [127:0] w, input logic [2:0] col);
        logic [127:0] r;
        logic [1:0]   idx;
        logic [31:0]  c;
        r = w;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            idx = col[1:0] + 2'(k);
            c   = w[127-32*int'(idx) -: 32];
            if (!last_q) begin
`ifdef MIX_COLUMNS_INV_EN
                c = inv_q ? mix_inv(c) : mix_fwd(c);
`else
                c = mix_fwd(c);
`endif
            end
            r[127-32*int'(idx) -: 32] = c;
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        col_d       = col_q;
        last_d      = last_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d       = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    work_d     = bus.data_in;
                    last_d     = bus.last_round;
`ifdef MIX_COLUMNS_INV_EN
                    inv_d      = bus.inv_mode;
`endif
                    col_d      = 3'd0;
                    in_ready_d = 1'b0;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                work_d = calc_step(work_q, col_q);
                col_d  = col_q + 3'(COLS_PER_CYCLE);
                if (col_d == 3'd4) begin
                    out_valid_d = 1'b1;
                    data_out_d  = work_d;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            col_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            col_q       <= col_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_mix_columns_iter.sv
// ============================================================================
// tb_aes_mix_columns_iter : runs COLS_PER_CYCLE=1/2/4 instances in lockstep
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] data_in = '0;
    logic         last_round = 1'b0;
    logic         out_ready = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv_mode = 1'b0;
`endif

    logic [2:0]   rdy, ov;
    logic [127:0] dout [3];

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mix_columns_iter_if u_if ();
        assign u_if.in_valid   = in_valid;
        assign u_if.data_in    = data_in;
        assign u_if.last_round = last_round;
        assign u_if.out_ready  = out_ready;
`ifdef MIX_COLUMNS_INV_EN
        assign u_if.inv_mode   = inv_mode;
`endif
        assign rdy[g]  = u_if.in_ready;
        assign ov[g]   = u_if.out_valid;
        assign dout[g] = u_if.data_out;

        aes_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if)
        );
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: generic shift-and-add GF(2^8) product and circulant matrix
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic lr, input logic inv);
        logic [127:0] res;
        logic [7:0]   acc;
        int           base [4];
        if (lr) return d;
        base = inv ? '{14, 11, 13, 9} : '{2, 3, 1, 1};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(8'(base[(j - r + 4) % 4]), d[127-32*c-8*j -: 8]);
                res[127-32*c-8*r -: 8] = acc;
            end
        return res;
    endfunction

    task automatic accept(input logic [127:0] d, input logic lr, input logic inv, input logic ordy, input string tag);
        int waited = 0;
        @(negedge clk);
        data_in    = d;
        last_round = lr;
        out_ready  = ordy;
`ifdef MIX_COLUMNS_INV_EN
        inv_mode   = inv;
`endif
        in_valid   = 1'b1;
        while (rdy != 3'b111 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s%s in_ready", tag, inv ? "/inv" : ""), 128'(rdy), 128'(3'b111));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] d, input logic lr, input logic inv,
                             input logic [127:0] exp, input string tag);
        int           lat [3];
        logic [127:0] got [3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            got[i] = '0;
        end
        accept(d, lr, inv, 1'b1, tag);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++)
                if (ov[i] && lat[i] == 0) begin
                    lat[i] = k;
                    got[i] = dout[i];
                end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s latency cpc%0d", tag, 1 << i), 128'(lat[i]), 128'(4 >> i));
            check($sformatf("%s data cpc%0d", tag, 1 << i), got[i], exp);
        end
    endtask

    initial begin
        logic [127:0] d;
        logic         lr, inv;

        // Reset with in_valid asserted: nothing accepted, outputs at reset values
        in_valid = 1'b1;
        data_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 128'(rdy), 128'(3'b111));
        check("reset out_valid", 128'(ov), 128'(3'b000));
        for (int i = 0; i < 3; i++) check($sformatf("reset data_out cpc%0d", 1 << i), dout[i], '0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset idle", 128'({rdy, ov}), 128'(6'b111_000));

        run_block(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
                  128'h046681e5e0cb199a48f8d37a2806264c, "fips");
        run_block(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0,
                  128'h8e4da1bc9fdc589d01010101c6c6c6c6, "known_cols");

        // Backpressure with bypass: result held stable while out_ready=0
        d = 128'h00112233445566778899aabbccddeeff;
        accept(d, 1'b1, 1'b0, 1'b0, "bp");
        repeat (4) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold %0d valid/ready", k), 128'({ov, rdy}), 128'(6'b111_000));
            for (int i = 0; i < 3; i++) check($sformatf("bp hold %0d data cpc%0d", k, 1 << i), dout[i], d);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release idle", 128'({ov, rdy}), 128'(6'b000_111));

        // Async reset while the cpc1 instance is mid-CALC at counter=2
        accept(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0, 1'b0, "midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst out_valid", 128'(ov), 128'(3'b000));
        check("midrst in_ready", 128'(rdy), 128'(3'b111));
        for (int i = 0; i < 3; i++) check($sformatf("midrst data_out cpc%0d", 1 << i), dout[i], '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
                  128'h046681e5e0cb199a48f8d37a2806264c, "after_midrst");

`ifdef MIX_COLUMNS_INV_EN
        run_block(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 1'b1,
                  128'hd4bf5d30e0b452aeb84111f11e2798e5, "inv_fips");
        run_block(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b1,
                  128'h046681e5e0cb199a48f8d37a2806264c, "inv_bypass");
`endif

        for (int n = 0; n < 16; n++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            lr = ($urandom_range(0, 3) == 0);
`ifdef MIX_COLUMNS_INV_EN
            inv = 1'($urandom_range(0, 1));
`else
            inv = 1'b0;
`endif
            run_block(d, lr, inv, model(d, lr, inv), $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
